gen2_cmd_framer: RTL and testbench
==================================

Name: gen2_cmd_framer

Overview:
- Reader-side command framer sitting directly upstream of pie_encoder.
- Accepts one EPC Gen2 command request (Query, QueryRep or ACK) as parallel fields and serialises it MSB-first onto pie_encoder's in_bit/in_rdy pull interface.
- Computes and appends CRC-5 for Query on the fly.
- Tells the encoder whether to emit a full preamble (Query) or a frame-sync (QueryRep, ACK).

Parameters:
- CRC5_PRESET, 5'b01001, CRC-5 register preset.
- CRC5_POLY, 5'b01001, CRC-5 feedback taps (x^5+x^3+1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request pulse; fields sampled on this edge
- cmd_type  in  2  00 Query, 01 QueryRep, 10 ACK, 11 reserved
- q_dr  in  1  Query DR
- q_m  in  2  Query M
- q_trext  in  1  Query TRext
- q_sel  in  2  Query Sel
- session  in  2  Session (Query and QueryRep)
- q_target  in  1  Query Target
- q_q  in  4  Query Q
- rn16  in  16  ACK payload
- enc_rdy  in  1  from pie_encoder in_rdy; high = current out_bit consumed this edge
- out_bit  out  1  to pie_encoder in_bit
- out_active  out  1  frame in progress; encoder gate
- out_preamble  out  1  to pie_encoder output_pie_preamble
- busy  out  1  framer occupied
- done  out  1  one-cycle pulse after last bit consumed
- err  out  1  one-cycle pulse on reserved cmd_type

Behaviour:
- Reset (rst low, async): state IDLE; out_bit, out_active, out_preamble, busy, done and err all 0; shift register and CRC cleared.
- IDLE:
  - start with cmd_type 11: err=1 next cycle, stay IDLE.
  - start with a valid cmd_type: latch the frame into a 22-bit shift register, left-justified; load bit count; CRC := CRC5_PRESET. Go to SEND.
- Frame contents:
  - Query: 1000, DR, M, TRext, Sel, Session, Target, Q (17 bits), then 5 CRC bits; total 22.
  - QueryRep: 00, Session; total 4.
  - ACK: 01, RN16; total 18.
- SEND:
  - Entry cycle: busy=1, out_active=1, out_preamble=1 for Query and 0 otherwise, out_bit=first bit. These three outputs are registered.
  - out_bit is held stable until an edge with enc_rdy=1.
  - On that edge: advance to the next bit and decrement the count.
  - Query only: for each of the 17 payload bits consumed, update the CRC: fb=crc[4]^bit; crc={crc[3:0],1'b0}^(fb?CRC5_POLY:0). After the 17th payload bit, out_bit presents crc[4] down to crc[0] in turn (MSB first), with no CRC update during CRC bits.
  - When enc_rdy is seen on the last bit: go to DONE.
- DONE, one cycle: done=1; out_active=0; out_preamble=0; busy=0; out_bit=0. Then go to IDLE.
- start while busy: ignored, with no field capture.
- enc_rdy while IDLE or DONE: ignored.
- Back-to-back: start is accepted in the cycle after done. The minimum frame gap is one cycle.
- enc_rdy held high continuously: one bit is consumed per cycle and the CRC still matches.
- Reset asserted mid-frame: all outputs immediately 0. Resume is not supported; the frame is lost.
- Latency:
  - start edge to out_active high: 1 cycle.
  - Final enc_rdy edge to done pulse: 1 cycle.

Test Plan:
- Query with all fields 0, enc_rdy pulsed every 8 cycles -> out_preamble=1; the 22 bits consumed are 1000_0000000000000_10000; done pulses once; busy falls with done.
- QueryRep with session=2'b10, enc_rdy every cycle -> out_preamble=0; bits consumed 0010; done 1 cycle after the 4th consumption.
- ACK with rn16=16'hA5C3 -> 18 bits 01_1010010111000011, out_preamble=0; no CRC appended.
- Query with randomised fields, enc_rdy random -> consumed bits match a bench CRC-5 model (preset 01001, poly 01001); out_bit is stable between enc_rdy edges.
- start asserted mid-frame with a different cmd_type; cmd_type=11 while IDLE -> the in-flight frame is unaffected; err pulses exactly once for the reserved request, with busy staying 0.
- rst pulled low after the 10th bit of a Query, then released, then a new QueryRep -> all outputs 0 while in reset; the next frame is clean and its CRC is unaffected by the aborted one.

Source files
------------

// File: rtl/gen2_cmd_framer.sv
// EPC Gen2 reader command framer: serialises Query / QueryRep / ACK MSB-first onto the
// pie_encoder pull interface, appending CRC-5 to Query on the fly.
module gen2_cmd_framer #(
    parameter logic [4:0] CRC5_PRESET = 5'b01001,
    parameter logic [4:0] CRC5_POLY   = 5'b01001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  cmd_type,
    input  logic        q_dr,
    input  logic [1:0]  q_m,
    input  logic        q_trext,
    input  logic [1:0]  q_sel,
    input  logic [1:0]  session,
    input  logic        q_target,
    input  logic [3:0]  q_q,
    input  logic [15:0] rn16,
    input  logic        enc_rdy,
    output logic        out_bit,
    output logic        out_active,
    output logic        out_preamble,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [4:0] crc5_step(input logic [4:0] crc, input logic din,
                                             input logic [4:0] poly);
        logic fb;
        fb        = crc[4] ^ din;
        crc5_step = {crc[3:0], 1'b0} ^ (fb ? poly : 5'b00000);
    endfunction

    state_t      state_q, state_d;
    logic [21:0] shift_q, shift_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [4:0]  crc_q, crc_d;
    logic        query_q, query_d;
    logic        bit_q, bit_d;
    logic        active_q, active_d;
    logic        pre_q, pre_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic [21:0] frame_s;
    logic [4:0]  len_s;
    logic        valid_s;
    logic        is_query_s;
    logic [21:0] shift_nx_s;
    logic [4:0]  crc_upd_s;

    // Frame image for the requested command, left-justified in the shift register
    always_comb begin
        frame_s    = 22'd0;
        len_s      = 5'd0;
        valid_s    = 1'b1;
        is_query_s = 1'b0;
        case (cmd_type)
            2'b00: begin
                frame_s    = {4'b1000, q_dr, q_m, q_trext, q_sel, session, q_target, q_q, 5'b00000};
                len_s      = 5'd22;
                is_query_s = 1'b1;
            end
            2'b01: begin
                frame_s = {2'b00, session, 18'd0};
                len_s   = 5'd4;
            end
            2'b10: begin
                frame_s = {2'b01, rn16, 4'd0};
                len_s   = 5'd18;
            end
            default: begin
                valid_s = 1'b0;
            end
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        crc_d      = crc_q;
        query_d    = query_q;
        bit_d      = bit_q;
        active_d   = active_q;
        pre_d      = pre_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        shift_nx_s = {shift_q[20:0], 1'b0};
        crc_upd_s  = crc_q;
        case (state_q)
            ST_IDLE: begin
                if (start && valid_s) begin
                    shift_d  = frame_s;
                    bit_d    = frame_s[21];
                    cnt_d    = len_s;
                    crc_d    = CRC5_PRESET;
                    query_d  = is_query_s;
                    active_d = 1'b1;
                    pre_d    = is_query_s;
                    busy_d   = 1'b1;
                    state_d  = ST_SEND;
                end else if (start) begin
                    err_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (enc_rdy && (cnt_q == 5'd1)) begin
                    bit_d    = 1'b0;
                    active_d = 1'b0;
                    pre_d    = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = ST_DONE;
                end else if (enc_rdy) begin
                    // Payload bits feed the CRC; once the last one goes, the CRC
                    // replaces the empty tail of the shift register.
                    if (query_q && (cnt_q > 5'd5)) begin
                        crc_upd_s = crc5_step(crc_q, bit_q, CRC5_POLY);
                        crc_d     = crc_upd_s;
                    end else begin
                        crc_d = crc_q;
                    end
                    if (query_q && (cnt_q == 5'd6)) begin
                        shift_nx_s[21:17] = crc_upd_s;
                    end else begin
                        shift_nx_s[21:17] = shift_nx_s[21:17];
                    end
                    shift_d = shift_nx_s;
                    bit_d   = shift_nx_s[21];
                    cnt_d   = cnt_q - 5'd1;
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d  = ST_IDLE;
                bit_d    = 1'b0;
                active_d = 1'b0;
                pre_d    = 1'b0;
                busy_d   = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            shift_q  <= 22'd0;
            cnt_q    <= 5'd0;
            crc_q    <= 5'd0;
            query_q  <= 1'b0;
            bit_q    <= 1'b0;
            active_q <= 1'b0;
            pre_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            cnt_q    <= cnt_d;
            crc_q    <= crc_d;
            query_q  <= query_d;
            bit_q    <= bit_d;
            active_q <= active_d;
            pre_q    <= pre_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign out_bit      = bit_q;
    assign out_active   = active_q;
    assign out_preamble = pre_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_gen2_cmd_framer.sv
// Scoreboard bench for gen2_cmd_framer: the driver pushes each frame's expected bits,
// a negedge monitor pops and compares whatever the encoder side consumes.
module tb_gen2_cmd_framer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  cmd_type = 2'b00;
    logic        q_dr = 1'b0;
    logic [1:0]  q_m = 2'b00;
    logic        q_trext = 1'b0;
    logic [1:0]  q_sel = 2'b00;
    logic [1:0]  session = 2'b00;
    logic        q_target = 1'b0;
    logic [3:0]  q_q = 4'd0;
    logic [15:0] rn16 = 16'd0;
    logic        enc_rdy = 1'b0;
    logic        out_bit, out_active, out_preamble, busy, done, err;

    gen2_cmd_framer dut (
        .clk(clk), .rst(rst), .start(start), .cmd_type(cmd_type), .q_dr(q_dr), .q_m(q_m),
        .q_trext(q_trext), .q_sel(q_sel), .session(session), .q_target(q_target), .q_q(q_q),
        .rn16(rn16), .enc_rdy(enc_rdy), .out_bit(out_bit), .out_active(out_active),
        .out_preamble(out_preamble), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic b;
        logic last;
        logic pre;
    } exp_t;

    exp_t sb_q[$];
    logic fb_q[$];
    int   cmp_cnt = 0;
    int   fail_cnt = 0;
    int   consumed_cnt = 0;
    int   frames_completed = 0;
    int   err_seen = 0;
    int   exp_err = 0;
    int   rdy_mode = 0;
    int   cyc = 0;
    logic pending_done = 1'b0;
    logic prev_active = 1'b0;
    logic prev_rdy = 1'b0;
    logic prev_bit = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void app(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) fb_q.push_back(v[i]);
    endfunction

    // Reference: the frame as the air-interface bit list, CRC-5 over the Query payload
    task automatic build_model(input logic [1:0] cmd);
        logic [4:0] crc;
        logic       fb;
        fb_q.delete();
        case (cmd)
            2'b00: begin
                app(16'h8, 4); app({15'd0, q_dr}, 1); app({14'd0, q_m}, 2);
                app({15'd0, q_trext}, 1); app({14'd0, q_sel}, 2); app({14'd0, session}, 2);
                app({15'd0, q_target}, 1); app({12'd0, q_q}, 4);
                crc = 5'b01001;
                foreach (fb_q[i]) begin
                    fb  = crc[4] ^ fb_q[i];
                    crc = {crc[3:0], 1'b0} ^ (fb ? 5'b01001 : 5'b00000);
                end
                app({11'd0, crc}, 5);
            end
            2'b01: begin
                app(16'h0, 2); app({14'd0, session}, 2);
            end
            default: begin
                app(16'h1, 2); app(rn16, 16);
            end
        endcase
        foreach (fb_q[i]) sb_q.push_back('{b: fb_q[i], last: (i == fb_q.size() - 1), pre: (cmd == 2'b00)});
    endtask

    task automatic randomize_fields();
        q_dr = 1'($urandom); q_m = 2'($urandom); q_trext = 1'($urandom); q_sel = 2'($urandom);
        session = 2'($urandom); q_target = 1'($urandom); q_q = 4'($urandom); rn16 = 16'($urandom);
    endtask

    task automatic launch(input logic [1:0] cmd);
        logic first;
        @(posedge clk); #1;
        cmd_type = cmd;
        start = 1'b1;
        build_model(cmd);
        first = fb_q[0];
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("active_latency", {31'd0, out_active}, 32'd1);
        chk("busy_on_start", {31'd0, busy}, 32'd1);
        chk("first_bit", {31'd0, out_bit}, {31'd0, first});
    endtask

    task automatic wait_frame(input int target);
        int n = 0;
        while (frames_completed < target && n < 800) begin
            @(negedge clk);
            n++;
        end
        if (frames_completed < target) begin
            cmp_cnt++;
            fail_cnt++;
            $display("FAIL frame_timeout: completed %0d required %0d", frames_completed, target);
            sb_q.delete();
            pending_done = 1'b0;
            frames_completed = target;
        end
    endtask

    task automatic run_frame(input logic [1:0] cmd);
        int target;
        target = frames_completed + 1;
        launch(cmd);
        wait_frame(target);
    endtask

    // enc_rdy pattern generator
    initial begin
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: enc_rdy = 1'b1;
                1: enc_rdy = (cyc % 8 == 0);
                default: enc_rdy = 1'($urandom_range(0, 1));
            endcase
            cyc++;
        end
    end

    // Monitor: consumption, done timing, stability, err, reset values
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("reset_outputs", {26'd0, out_bit, out_active, out_preamble, busy, done, err}, 32'd0);
                prev_active = 1'b0;
                pending_done = 1'b0;
            end else begin
                if (pending_done) begin
                    chk("done_cycle", {27'd0, done, out_active, busy, out_preamble, out_bit}, 32'h10);
                    pending_done = 1'b0;
                    frames_completed++;
                end else if (done) begin
                    chk("spurious_done", {31'd0, done}, 32'd0);
                end
                if (err) begin
                    err_seen++;
                    chk("busy_on_err", {31'd0, busy}, 32'd0);
                end
                if (out_active && prev_active && !prev_rdy)
                    chk("bit_stable", {31'd0, out_bit}, {31'd0, prev_bit});
                if (out_active && enc_rdy) begin
                    if (sb_q.size() == 0) begin
                        chk("extra_bit", {31'd0, out_active}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb_q.pop_front();
                        chk("out_bit", {31'd0, out_bit}, {31'd0, e.b});
                        chk("out_preamble", {31'd0, out_preamble}, {31'd0, e.pre});
                        if (e.last) pending_done = 1'b1;
                    end
                    consumed_cnt++;
                end
                prev_active = out_active;
                prev_rdy = enc_rdy;
                prev_bit = out_bit;
            end
        end
    end

    initial begin
        int base;
        int n;
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);

        // All-zero Query, slow encoder
        rdy_mode = 1;
        q_dr = 1'b0; q_m = 2'b00; q_trext = 1'b0; q_sel = 2'b00;
        session = 2'b00; q_target = 1'b0; q_q = 4'd0;
        run_frame(2'b00);

        // QueryRep session 2, encoder always ready, then a back-to-back ACK
        rdy_mode = 0;
        session = 2'b10;
        run_frame(2'b01);
        rdy_mode = 2;
        rn16 = 16'hA5C3;
        run_frame(2'b10);

        // Randomised mix, mostly Query
        for (int k = 0; k < 24; k++) begin
            randomize_fields();
            rdy_mode = (k % 5 == 0) ? 0 : 2;
            run_frame((k % 4 == 3) ? 2'($urandom_range(1, 2)) : 2'b00);
        end

        // start while busy must be ignored
        rdy_mode = 2;
        randomize_fields();
        base = frames_completed + 1;
        launch(2'b00);
        repeat (6) @(posedge clk);
        #1;
        cmd_type = 2'b10; rn16 = 16'h1234; session = ~session; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame(base);

        // Reserved command while idle
        repeat (2) @(posedge clk);
        #1;
        cmd_type = 2'b11; start = 1'b1; exp_err++;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);

        // Abort a Query after its 10th bit, then clean frames
        rdy_mode = 0;
        randomize_fields();
        base = consumed_cnt;
        launch(2'b00);
        n = 0;
        while (consumed_cnt < base + 10 && n < 100) begin
            @(posedge clk); #2;
            n++;
        end
        rst = 1'b0;
        sb_q.delete();
        pending_done = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        session = 2'b01;
        run_frame(2'b01);
        randomize_fields();
        run_frame(2'b00);

        repeat (3) @(posedge clk);
        chk("err_pulses", err_seen, exp_err);
        chk("scoreboard_empty", sb_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
        $finish;
    end

endmodule
